// File: rtl/signal_pkg.sv
// Shared types and helpers for the signal sample chain (operator and decimator stages).
package signal_pkg;

  localparam int SIGNAL_DATA_W = 32;

  typedef logic [SIGNAL_DATA_W-1:0] sample_t;

  // Accumulator width that holds 2^decim_log2 full-scale samples without overflow.
  function automatic int acc_width(input int data_w, input int decim_log2);
    return data_w + decim_log2;
  endfunction

endpackage

// File: rtl/signal_decim_acc.sv
// Boxcar accumulator for the decimator: holds the partial sum and phase count and
// produces the completion strobe and mean of the window being closed this cycle.
// Optional round-half-up of the mean is selected by SIGNAL_DECIMATOR_ROUND_EN.
module signal_decim_acc
  import signal_pkg::*;
#(
  parameter int DATA_W     = SIGNAL_DATA_W,
  parameter int DECIM_LOG2 = 2,
  localparam int PH_W      = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [DATA_W-1:0] data,
  output logic              last,
  output logic              complete,
  output logic [DATA_W-1:0] result,
  output logic [PH_W-1:0]   phase
);

  localparam int ACC_W = acc_width(DATA_W, DECIM_LOG2);
  localparam int N     = 1 << DECIM_LOG2;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(N - 1);
`ifdef SIGNAL_DECIMATOR_ROUND_EN
  // Half an LSB of the output; zero when N = 1, so pass-through is untouched.
  localparam logic [ACC_W-1:0] RND = ACC_W'(N >> 1);
`else
  localparam logic [ACC_W-1:0] RND = '0;
`endif

  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [PH_W-1:0]  phase_reg, phase_next;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] sum_rnd;

  // Running sum including the sample on the input; ACC_W is wide enough that neither add wraps.
  assign sum      = acc_reg + ACC_W'(data);
  assign sum_rnd  = sum + RND;
  assign result   = DATA_W'(sum_rnd >> DECIM_LOG2);
  assign last     = (phase_reg == PH_LAST);
  assign complete = accept && last && !clear;
  assign phase    = phase_reg;

  // Next-state: clear wins, the completing sample restarts the window, others accumulate.
  always_comb begin
    acc_next   = acc_reg;
    phase_next = phase_reg;
    if (clear) begin
      acc_next   = '0;
      phase_next = '0;
    end else if (accept) begin
      if (last) begin
        acc_next   = '0;
        phase_next = '0;
      end else begin
        acc_next   = sum;
        phase_next = phase_reg + PH_W'(1);
      end
    end
  end

  // Accumulator and phase registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg   <= '0;
      phase_reg <= '0;
    end else begin
      acc_reg   <= acc_next;
      phase_reg <= phase_next;
    end
  end

endmodule

// File: rtl/signal_decimator.sv
// Decimating boxcar averager on an Avalon-ST sample chain: averages 2^DECIM_LOG2
// accepted samples into one output beat held in a single-entry output register.
// Define SIGNAL_DECIMATOR_ROUND_EN to round the mean half up instead of truncating.
module signal_decimator
  import signal_pkg::*;
#(
  parameter int DATA_W     = SIGNAL_DATA_W,
  parameter int DECIM_LOG2 = 2,
  localparam int PH_W      = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              avalonst_sink_valid,
  input  logic [DATA_W-1:0] avalonst_sink_data,
  output logic              avalonst_sink_ready,
  output logic              avalonst_source_valid,
  output logic [DATA_W-1:0] avalonst_source_data,
  input  logic              avalonst_source_ready,
  output logic [PH_W-1:0]   phase
);

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              accept;
  logic              last;
  logic              complete;
  logic [DATA_W-1:0] result;

  // Only the completing sample can be blocked, and only while the result slot is stuck.
  assign avalonst_sink_ready   = !clear && !(last && out_valid_reg && !avalonst_source_ready);
  assign accept                = avalonst_sink_valid && avalonst_sink_ready;
  assign avalonst_source_valid = out_valid_reg;
  assign avalonst_source_data  = out_data_reg;

  signal_decim_acc #(
    .DATA_W     (DATA_W),
    .DECIM_LOG2 (DECIM_LOG2)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .accept   (accept),
    .data     (avalonst_sink_data),
    .last     (last),
    .complete (complete),
    .result   (result),
    .phase    (phase)
  );

  // Output register: a completion always loads (the slot is free or draining this cycle),
  // otherwise a transfer empties it; clear leaves a pending result in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (complete) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= result;
    end else if (out_valid_reg && avalonst_source_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_signal_decimator.sv
// Directed self-checking bench for signal_decimator (N = 4).
module tb_signal_decimator;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        sink_valid;
  logic [31:0] sink_data;
  logic        sink_ready;
  logic        source_valid;
  logic [31:0] source_data;
  logic        source_ready;
  logic [1:0]  phase;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  signal_decimator #(
    .DATA_W     (32),
    .DECIM_LOG2 (2)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .clear                 (clear),
    .avalonst_sink_valid   (sink_valid),
    .avalonst_sink_data    (sink_data),
    .avalonst_sink_ready   (sink_ready),
    .avalonst_source_valid (source_valid),
    .avalonst_source_data  (source_data),
    .avalonst_source_ready (source_ready),
    .phase                 (phase)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    sink_valid = 1'b1;
    sink_data  = d;
    tick();
    sink_valid = 1'b0;
  endtask

  logic [31:0] exp_rnd;

  initial begin
    reset = 1'b1; clear = 1'b0; sink_valid = 1'b0; sink_data = '0; source_ready = 1'b1;
    #12 reset = 1'b0;
    #1;
    check("rst_valid", {31'd0, source_valid}, 32'd0);
    check("rst_data",  source_data, 32'd0);
    check("rst_phase", {30'd0, phase}, 32'd0);
    check("rst_ready", {31'd0, sink_ready}, 32'd1);
    tick();

    // Basic average, back-to-back.
    send(10); send(20);
    check("t1_phase2", {30'd0, phase}, 32'd2);
    check("t1_early_valid", {31'd0, source_valid}, 32'd0);
    send(30); send(40);
    check("t1_valid", {31'd0, source_valid}, 32'd1);
    check("t1_data",  source_data, 32'd25);
    check("t1_phase0", {30'd0, phase}, 32'd0);
    tick();
    check("t1_single_beat", {31'd0, source_valid}, 32'd0);
    $display("t1 average 10,20,30,40 -> %0d", 25);

    // Truncate vs round.
`ifdef SIGNAL_DECIMATOR_ROUND_EN
    exp_rnd = 32'd2;
`else
    exp_rnd = 32'd1;
`endif
    send(1); send(2); send(2); send(2);
    check("t2_valid", {31'd0, source_valid}, 32'd1);
    check("t2_data",  source_data, exp_rnd);
    tick();
    $display("t2 average 1,2,2,2 -> expected %0d", exp_rnd);

    // Full scale, no wrap.
    send(32'hFFFF_FFFF); send(32'hFFFF_FFFF); send(32'hFFFF_FFFF); send(32'hFFFF_FFFF);
    check("t3_valid", {31'd0, source_valid}, 32'd1);
    check("t3_data",  source_data, 32'hFFFF_FFFF);
    tick();
    $display("t3 full-scale average -> 0xffffffff");

    // Backpressure.
    source_ready = 1'b0;
    send(10); send(20); send(30); send(40);
    check("t4_first_valid", {31'd0, source_valid}, 32'd1);
    check("t4_first_data",  source_data, 32'd25);
    send(50); send(60); send(70);
    check("t4_phase3", {30'd0, phase}, 32'd3);
    sink_valid = 1'b1; sink_data = 32'd80;
    #1;
    check("t4_ready_low", {31'd0, sink_ready}, 32'd0);
    tick(); tick();
    check("t4_hold_phase", {30'd0, phase}, 32'd3);
    check("t4_hold_data",  source_data, 32'd25);
    check("t4_hold_valid", {31'd0, source_valid}, 32'd1);
    source_ready = 1'b1;
    #1;
    check("t4_ready_comb", {31'd0, sink_ready}, 32'd1);
    tick();
    sink_valid = 1'b0;
    check("t4_second_valid", {31'd0, source_valid}, 32'd1);
    check("t4_second_data",  source_data, 32'd65);
    check("t4_second_phase", {30'd0, phase}, 32'd0);
    tick();
    check("t4_drained", {31'd0, source_valid}, 32'd0);
    $display("t4 backpressure results 25 then 65");

    // Clear mid-window.
    send(5); send(7);
    check("t5_phase2", {30'd0, phase}, 32'd2);
    clear = 1'b1; sink_valid = 1'b1; sink_data = 32'd99;
    #1;
    check("t5_clear_ready", {31'd0, sink_ready}, 32'd0);
    tick();
    clear = 1'b0; sink_valid = 1'b0;
    check("t5_clear_phase", {30'd0, phase}, 32'd0);
    check("t5_clear_valid", {31'd0, source_valid}, 32'd0);
    send(4); send(4); send(4); send(4);
    source_ready = 1'b0;
    check("t5_valid", {31'd0, source_valid}, 32'd1);
    check("t5_data",  source_data, 32'd4);
    $display("t5 clear then 4,4,4,4 -> 4");

    // Reset mid-window with a pending result.
    send(100); send(100); send(100);
    check("t6_pending_data",  source_data, 32'd4);
    check("t6_pre_phase", {30'd0, phase}, 32'd3);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", {31'd0, source_valid}, 32'd0);
    check("t6_rst_data",  source_data, 32'd0);
    check("t6_rst_phase", {30'd0, phase}, 32'd0);
    #2 reset = 1'b0;
    source_ready = 1'b1;
    tick();
    send(8); send(8);
    tick();
    check("t6_gap_phase", {30'd0, phase}, 32'd2);
    send(8); send(8);
    check("t6_valid", {31'd0, source_valid}, 32'd1);
    check("t6_data",  source_data, 32'd8);
    tick();
    check("t6_single_beat", {31'd0, source_valid}, 32'd0);
    $display("t6 reset then 8,8,gap,8,8 -> 8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
